// File: rtl/bank_rf_pkg.sv
// Shared types for the banked write-queued register file.
// Sweep/run state and ring-buffer index helper.
package bank_rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  function automatic int ring_idx(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bank_mpregfile_nr2w_wq_bank.sv
// One register bank: NR async read ports, one sync write port.
// FPGA build keeps one LUTRAM copy per group of three readers.
module bank_rf_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 16,
  parameter int NR    = 4,
  parameter int RW    = 4
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [RW-1:0]              wrow_i,
  input  logic [WIDTH-1:0]           wd_i,
  input  logic [NR-1:0][RW-1:0]      rrow_i,
  output logic [NR-1:0][WIDTH-1:0]   rd_o
);

`ifdef _FPGA
  localparam int NG = (NR + 2) / 3;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [WIDTH-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
      if (we_i) mem_q[wrow_i] <= wd_i;
    end

    for (genvar p = 3 * g; (p < NR) && (p < 3 * g + 3); p++) begin : g_rd
      assign rd_o[p] = mem_q[rrow_i[p]];
    end
  end
`else
  logic [WIDTH-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wrow_i] <= wd_i;
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    assign rd_o[p] = mem_q[rrow_i[p]];
  end
`endif

endmodule

// File: rtl/bank_mpregfile_nr2w_wq.sv
// Banked NR-read / 2-write register file with a conflict write queue
// and a post-reset zero-fill sweep.
module bank_mpregfile_nr2w_wq
  import bank_rf_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int NBANK      = 2,
  parameter int NR         = 4,
  parameter int WQ_DEPTH   = 2,
  parameter bit RESET_NEED = 1'b1,
  parameter bit ZERO_REG   = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(WQ_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR-1:0][AW-1:0]     ra_i,
  output logic [NR-1:0][WIDTH-1:0]  rd_o,
  input  logic                      we0_i,
  input  logic [AW-1:0]             wa0_i,
  input  logic [WIDTH-1:0]          wd0_i,
  input  logic                      we1_i,
  input  logic [AW-1:0]             wa1_i,
  input  logic [WIDTH-1:0]          wd1_i,
  output logic                      wr_ready_o,
  output logic                      init_busy_o,
  output logic                      conflict_o,
  output logic [CW-1:0]             wq_cnt_o
);

  localparam int BW   = $clog2(NBANK);
  localparam int RW   = AW - BW;
  localparam int ROWS = DEPTH / NBANK;
  localparam int PW   = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wq_entry_t;

  function automatic logic [PW-1:0] slot(
    input logic [PW-1:0] base,
    input int            off
  );
    return PW'(ring_idx(int'(base), off, WQ_DEPTH));
  endfunction

  rf_state_e       state_q, state_d;
  logic [RW-1:0]   sweep_q, sweep_d;
  wq_entry_t       wq_q [WQ_DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            run, sweeping;
  logic            pop, v0, v1, match0, match1;
  logic            dir0, dir1, push0, push1;
  logic [BW-1:0]   hb, b0, b1;
  wq_entry_t       head_e;

  logic                       bwe  [NBANK];
  logic [RW-1:0]              brow [NBANK];
  logic [WIDTH-1:0]           bwd  [NBANK];
  logic [NR-1:0][WIDTH-1:0]   brd  [NBANK];
  logic [NR-1:0][RW-1:0]      rrow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_NEED ? RF_INIT : RF_RUN;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == RF_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == RW'(ROWS - 1)) state_d = RF_RUN;
    end
  end

  always_comb begin
    run         = rst_n && (state_q == RF_RUN);
    sweeping    = rst_n && (state_q == RF_INIT);
    init_busy_o = rst_n ? (state_q == RF_INIT) : RESET_NEED;
    wr_ready_o  = run && ((WQ_DEPTH - int'(cnt_q)) >= 2);
  end

  assign head_e = wq_q[head_q];
  assign hb     = head_e.addr[BW-1:0];
  assign b0     = wa0_i[BW-1:0];
  assign b1     = wa1_i[BW-1:0];

  always_comb begin
    match0 = 1'b0;
    match1 = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        if (wq_q[slot(head_q, i)].addr == wa0_i) match0 = 1'b1;
        if (wq_q[slot(head_q, i)].addr == wa1_i) match1 = 1'b1;
      end
    end
  end

  // Head owns its bank; port1 must queue behind a queued port0 to the same addr.
  always_comb begin
    pop   = run && (cnt_q != '0);
    v0    = we0_i && wr_ready_o && !(ZERO_REG && (wa0_i == '0));
    v1    = we1_i && wr_ready_o && !(ZERO_REG && (wa1_i == '0));
    dir0  = v0 && !(pop && (hb == b0)) && !match0;
    push0 = v0 && !dir0;
    dir1  = v1 && !(pop && (hb == b1)) && !(dir0 && (b0 == b1))
               && !match1 && !(push0 && (wa0_i == wa1_i));
    push1 = v1 && !dir1;
    conflict_o = push0 || push1;
    head_d = pop ? slot(head_q, 1) : head_q;
    tail_d = slot(tail_q, int'(push0) + int'(push1));
    cnt_d  = cnt_q - CW'(pop) + CW'(push0) + CW'(push1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) wq_q[tail_q] <= '{addr: wa0_i, data: wd0_i};
    if (push1) wq_q[push0 ? slot(tail_q, 1) : tail_q] <= '{addr: wa1_i, data: wd1_i};
  end

  assign wq_cnt_o = cnt_q;

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bwe[b]  = 1'b0;
      brow[b] = '0;
      bwd[b]  = '0;
      unique case (1'b1)
        sweeping: begin
          bwe[b]  = 1'b1;
          brow[b] = sweep_q;
        end
        pop && (hb == BW'(b)): begin
          bwe[b]  = 1'b1;
          brow[b] = head_e.addr[AW-1:BW];
          bwd[b]  = head_e.data;
        end
        dir0 && (b0 == BW'(b)): begin
          bwe[b]  = 1'b1;
          brow[b] = wa0_i[AW-1:BW];
          bwd[b]  = wd0_i;
        end
        dir1 && (b1 == BW'(b)): begin
          bwe[b]  = 1'b1;
          brow[b] = wa1_i[AW-1:BW];
          bwd[b]  = wd1_i;
        end
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rrow
    assign rrow[p] = ra_i[p][AW-1:BW];
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    bank_rf_bank #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .NR    (NR),
      .RW    (RW)
    ) u_bank (
      .clk    (clk),
      .we_i   (bwe[g]),
      .wrow_i (brow[g]),
      .wd_i   (bwd[g]),
      .rrow_i (rrow),
      .rd_o   (brd[g])
    );
  end

  // Later queue slots are younger, so the last hit wins.
  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rd_o[p] = brd[ra_i[p][BW-1:0]][p];
      for (int i = 0; i < WQ_DEPTH; i++) begin
        if ((i < int'(cnt_q)) && (wq_q[slot(head_q, i)].addr == ra_i[p]))
          rd_o[p] = wq_q[slot(head_q, i)].data;
      end
      if (ZERO_REG && (ra_i[p] == '0)) rd_o[p] = '0;
    end
  end

  a_wr_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    !((we0_i || we1_i) && !wr_ready_o));

  a_wq_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt_q) <= WQ_DEPTH);

endmodule
